// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory-port arbiter: grant states and default widths.
package mem_port_arbiter_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2
  } state_e;

  function automatic int streak_width(input int max_streak);
    return $clog2(max_streak + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, LSU and memory-side signals around the arbiter; slave = arbiter view.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = XLEN,
  parameter int DATA_W = XLEN
);

  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic                  i_ack;
  logic [DATA_W-1:0]     i_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_wstrb;
  logic                  d_ack;
  logic [DATA_W-1:0]     d_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic                  mem_ready;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  mem_ready, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    output mem_ready, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

endinterface

// File: rtl/mem_port_arbiter_mux.sv
// Plain 2:1 word mux; b is selected when sel is high. Purely combinational.
module mem_port_arbiter_mux
  import mem_port_arbiter_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  output logic [W-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and LSU onto one memory port; grant registered, ack combinational on mem_ready.
// Memory-side signals are held for the whole access; requesters wait (no timeout) until acked.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = XLEN,
  parameter int DATA_W       = XLEN,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int STREAK_W = streak_width(MAX_D_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  state_e                state_q, state_d;
  logic [STREAK_W-1:0]   streak_q, streak_d;
  logic                  grant_i, grant_d;

  logic [ADDR_W-1:0]     addr_sel;
  logic [ADDR_W-1:0]     mem_addr_q;
  logic [DATA_W-1:0]     mem_wdata_q;
  logic [STRB_W-1:0]     mem_wstrb_q;
  logic                  mem_we_q;

  // D wins ties unless it has already starved a waiting fetch for MAX_D_STREAK grants.
  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.d_req && (!bus.i_req || streak_q != STREAK_MAX)) begin
          state_d = ST_GRANT_D;
          grant_d = 1'b1;
        end else if (bus.i_req) begin
          state_d = ST_GRANT_I;
          grant_i = 1'b1;
        end
      end
      ST_GRANT_I, ST_GRANT_D: begin
        if (bus.mem_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    streak_d = streak_q;
    if (grant_i) begin
      streak_d = '0;
    end else if (grant_d) begin
      if (!bus.i_req) begin
        streak_d = '0;
      end else if (streak_q != STREAK_MAX) begin
        streak_d = streak_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  mem_port_arbiter_mux #(
    .W (ADDR_W)
  ) u_addr_mux (
    .a   (bus.i_addr),
    .b   (bus.d_addr),
    .sel (grant_d),
    .y   (addr_sel)
  );

  // Fetches are always reads: write controls are forced to zero on an I grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else if (grant_i || grant_d) begin
      mem_addr_q  <= addr_sel;
      mem_we_q    <= grant_d & bus.d_we;
      mem_wdata_q <= grant_d ? bus.d_wdata : '0;
      mem_wstrb_q <= grant_d ? bus.d_wstrb : '0;
    end
  end

  assign bus.mem_req   = (state_q != ST_IDLE);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;

  assign bus.i_ack   = (state_q == ST_GRANT_I) && bus.mem_ready;
  assign bus.d_ack   = (state_q == ST_GRANT_D) && bus.mem_ready;
  assign bus.i_rdata = bus.i_ack ? bus.mem_rdata : '0;
  assign bus.d_rdata = bus.d_ack ? bus.mem_rdata : '0;

  a_ack_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.i_ack && bus.d_ack));

  a_mem_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (bus.mem_req && !bus.mem_ready) |=>
      (bus.mem_req && $stable(bus.mem_addr) && $stable(bus.mem_we) &&
       $stable(bus.mem_wdata) && $stable(bus.mem_wstrb)));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table plus hand-built reset/fairness/spurious-ready sequences.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .MAX_D_STREAK (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          d;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    bit          is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lat;
    logic [31:0] rdata;
    bit          exp_d;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_rdata;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input bit d, input logic [31:0] addr, input logic we,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          input logic [31:0] rdata);
    exp_t e;
    e.d = d; e.addr = addr; e.we = we; e.wdata = wdata; e.wstrb = wstrb; e.rdata = rdata;
    sb.push_back(e);
  endtask

  // Every ack is matched against the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    #1;
    if (bus.i_ack || bus.d_ack) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'({bus.i_ack, bus.d_ack}), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_side_d", 32'(bus.d_ack), 32'(e.d));
        chk("ack_side_i", 32'(bus.i_ack), 32'(!e.d));
        chk("ack_rdata", e.d ? bus.d_rdata : bus.i_rdata, e.rdata);
        chk("other_rdata_zero", e.d ? bus.i_rdata : bus.d_rdata, 32'd0);
        chk("mem_addr", bus.mem_addr, e.addr);
        chk("mem_we", 32'(bus.mem_we), 32'(e.we));
        chk("mem_wdata", bus.mem_wdata, e.wdata);
        chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(e.wstrb));
      end
    end
  end

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    if (v.is_d) begin
      bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr;
      bus.d_wdata = v.wdata; bus.d_wstrb = v.wstrb;
      bus.i_req = 1'b0; bus.i_addr = 32'hBAD0_0000;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = v.addr;
      bus.d_req = 1'b0; bus.d_we = 1'b1; bus.d_addr = 32'hBAD0_0004;
      bus.d_wdata = 32'hFFFF_FFFF; bus.d_wstrb = 4'hF;
    end
    push_exp(v.exp_d, v.exp_addr, v.exp_we, v.exp_wdata, v.exp_wstrb, v.exp_rdata);
    for (int c = 0; c <= v.lat; c++) begin
      @(negedge clk);
      if (c == v.lat) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = v.rdata;
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = $urandom;
      end
      #2;
      chk("mem_req_active", 32'(bus.mem_req), 32'd1);
      if (c == v.lat)
        chk("ack_at_ready", 32'(v.exp_d ? bus.d_ack : bus.i_ack), 32'd1);
      else
        chk("no_ack_waiting", 32'({bus.i_ack, bus.d_ack}), 32'd0);
    end
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #2;
    chk("idle_after_ack", 32'(bus.mem_req), 32'd0);
  endtask

  vec_t vecs[5];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 3, 32'h0051_3093,
                1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'h0051_3093};
    vecs[1] = '{1'b1, 1'b1, 32'h1000_0008, 32'hDEAD_BEEF, 4'b0011, 0, 32'h1234_5678,
                1'b1, 1'b1, 32'h1000_0008, 32'hDEAD_BEEF, 4'b0011, 32'h1234_5678};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_2004, 32'h1111_1111, 4'h0, 1, 32'hCAFE_F00D,
                1'b1, 1'b0, 32'h0000_2004, 32'h1111_1111, 4'h0, 32'hCAFE_F00D};
    vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 2, 32'hFFFF_FFFF,
                1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 32'hFFFF_FFFF};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0000, 32'h0BAD_C0DE, 4'hF, 5, 32'h0000_0000,
                1'b1, 1'b1, 32'h0000_0000, 32'h0BAD_C0DE, 4'hF, 32'h0000_0000};

    // Reset asserted with both requesters active.
    rst_n = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0080;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h1234_5678;
    bus.d_wdata = 32'hA5A5_5A5A; bus.d_wstrb = 4'hF;
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_acks", 32'({bus.i_ack, bus.d_ack}), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
    push_exp(1'b1, 32'h1234_5678, 1'b1, 32'hA5A5_5A5A, 4'hF, 32'h5555_AAAA);
    rst_n = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h5555_AAAA;
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    #2;
    chk("post_rst_mem_req", 32'(bus.mem_req), 32'd1);
    chk("post_rst_grant_d", 32'(bus.d_ack), 32'd1);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #2;
    chk("post_rst_idle", 32'(bus.mem_req), 32'd0);

    foreach (vecs[k]) run_vec(vecs[k]);

    // Both requesters held with single-cycle memory: D,D,D,D,I repeating.
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_3000;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_2000;
    bus.d_wdata = 32'h0; bus.d_wstrb = 4'h0;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h600D_600D;
    for (int g = 0; g < 10; g++) begin
      if ((g % 5) == 4) push_exp(1'b0, 32'h0000_3000, 1'b0, 32'h0, 4'h0, 32'h600D_600D);
      else              push_exp(1'b1, 32'h0000_2000, 1'b0, 32'h0, 4'h0, 32'h600D_600D);
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    bus.i_req = 1'b0; bus.d_req = 1'b0; bus.mem_ready = 1'b0;
    #2;
    chk("fair_done_idle", 32'(bus.mem_req), 32'd0);
    chk("fair_all_acked", 32'(sb.size()), 32'd0);

    // Reset while a store waits on memory.
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_4000;
    bus.d_wdata = 32'h7777_8888; bus.d_wstrb = 4'hC;
    repeat (3) @(negedge clk);
    #2;
    chk("midrst_waiting", 32'(bus.mem_req), 32'd1);
    chk("midrst_addr", bus.mem_addr, 32'h0000_4000);
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("midrst_d_ack", 32'(bus.d_ack), 32'd0);
    chk("midrst_mem_addr", bus.mem_addr, 32'd0);
    chk("midrst_mem_we", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    bus.d_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    chk("midrst_idle", 32'(bus.mem_req), 32'd0);

    // Spurious mem_ready in IDLE must be ignored.
    @(negedge clk);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hFFFF_0000;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      #2;
      chk("spur_mem_req", 32'(bus.mem_req), 32'd0);
      chk("spur_acks", 32'({bus.i_ack, bus.d_ack}), 32'd0);
      chk("spur_rdata", bus.i_rdata | bus.d_rdata, 32'd0);
    end
    @(negedge clk);
    bus.mem_ready = 1'b0;
    run_vec(vecs[0]);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
